// File: rtl/arm_ex_pkg.sv
// Shared types for the execute stage: ALU opcodes, shift kinds, MAC FSM states and flag positions.
package arm_ex_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
        OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
        OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
        OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} shift_e;

    typedef enum logic [1:0] {MAC_IDLE = 2'd0, MAC_MUL = 2'd1, MAC_DONE = 2'd2} mac_state_e;

    // Index into a 4-bit {N,Z,C,V} vector; the CPSR holds it at bits 31..28.
    localparam int FLAG_N        = 3;
    localparam int FLAG_Z        = 2;
    localparam int FLAG_C        = 1;
    localparam int FLAG_V        = 0;
    localparam int CPSR_FLAG_LSB = 28;

    function automatic logic [31:0] merge_flags(input logic [31:0] cpsr,
                                                input logic [3:0]  nzcv,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = cpsr;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[CPSR_FLAG_LSB + i] = nzcv[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/arm_ex_if.sv
// ID<->EX bus: the IDEX pipeline register contents and the EX status fed back to decode.
interface arm_ex_if;
    logic [31:0] IDEX_rn_data, IDEX_rm_data, IDEX_rs_or_rd_data, IDEX_cpsr;
    logic [11:0] IDEX_inst_11_0;
    logic [3:0]  IDEX_inst_19_16, IDEX_inst_15_12;
    logic [3:0]  IDEX_alu_sel, IDEX_cpsr_mask, IDEX_mem_write_en;
    logic        IDEX_rd_we, IDEX_cpsr_we, IDEX_rd_sel, IDEX_rd_data_sel, IDEX_is_imm;
    logic        IDEX_alu_or_mac, IDEX_up_down, IDEX_mac_sel, IDEX_is_alu_for_mem_addr;
    logic        IDEX_ld_byte_or_word;

    logic        EXID_rd_we, EXID_cpsr_we, EXID_alu_or_mac, EXID_is_alu_for_mem_addr;
    logic [3:0]  EXID_rd_num;
    logic [31:0] EXID_forward_data, EXID_cpsr;

    modport master (
        output IDEX_rn_data, IDEX_rm_data, IDEX_rs_or_rd_data, IDEX_cpsr, IDEX_inst_11_0,
               IDEX_inst_19_16, IDEX_inst_15_12, IDEX_alu_sel, IDEX_cpsr_mask, IDEX_mem_write_en,
               IDEX_rd_we, IDEX_cpsr_we, IDEX_rd_sel, IDEX_rd_data_sel, IDEX_is_imm,
               IDEX_alu_or_mac, IDEX_up_down, IDEX_mac_sel, IDEX_is_alu_for_mem_addr,
               IDEX_ld_byte_or_word,
        input  EXID_rd_we, EXID_cpsr_we, EXID_alu_or_mac, EXID_is_alu_for_mem_addr,
               EXID_rd_num, EXID_forward_data, EXID_cpsr
    );

    modport slave (
        input  IDEX_rn_data, IDEX_rm_data, IDEX_rs_or_rd_data, IDEX_cpsr, IDEX_inst_11_0,
               IDEX_inst_19_16, IDEX_inst_15_12, IDEX_alu_sel, IDEX_cpsr_mask, IDEX_mem_write_en,
               IDEX_rd_we, IDEX_cpsr_we, IDEX_rd_sel, IDEX_rd_data_sel, IDEX_is_imm,
               IDEX_alu_or_mac, IDEX_up_down, IDEX_mac_sel, IDEX_is_alu_for_mem_addr,
               IDEX_ld_byte_or_word,
        output EXID_rd_we, EXID_cpsr_we, EXID_alu_or_mac, EXID_is_alu_for_mem_addr,
               EXID_rd_num, EXID_forward_data, EXID_cpsr
    );
endinterface

// File: rtl/arm_shifter.sv
// Operand-2 barrel shifter: rotated 8-bit immediate or shift-by-immediate of rm, with carry-out.
// Purely combinational; no flow control.
module arm_shifter
    import arm_ex_pkg::*;
(
    input  logic        imm_mode,
    input  logic [11:0] operand,
    input  logic [31:0] rm_data,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out
);

    logic [63:0] rot64;
    logic [32:0] ext;
    logic [4:0]  imm_rot;
    logic [5:0]  amt;
    logic        amt_zero;

    assign amt_zero = (operand[11:7] == 5'd0);

    always_comb begin
        result    = rm_data;
        carry_out = carry_in;
        rot64     = '0;
        ext       = '0;
        imm_rot   = {operand[11:8], 1'b0};
        // LSR/ASR #0 encode a shift by 32
        amt       = amt_zero ? 6'd32 : {1'b0, operand[11:7]};
        if (imm_mode) begin
            rot64  = {2{24'd0, operand[7:0]}} >> imm_rot;
            result = rot64[31:0];
            if (imm_rot != 5'd0) carry_out = rot64[31];
        end else begin
            case (shift_e'(operand[6:5]))
                SH_LSL: if (!amt_zero) begin
                    ext       = {1'b0, rm_data} << operand[11:7];
                    result    = ext[31:0];
                    carry_out = ext[32];
                end
                SH_LSR: begin
                    ext       = {rm_data, 1'b0} >> amt;
                    result    = ext[32:1];
                    carry_out = ext[0];
                end
                SH_ASR: begin
                    ext       = $signed({rm_data, 1'b0}) >>> amt;
                    result    = ext[32:1];
                    carry_out = ext[0];
                end
                SH_ROR: if (amt_zero) begin
                    result    = {carry_in, rm_data[31:1]};
                    carry_out = rm_data[0];
                end else begin
                    rot64     = {rm_data, rm_data} >> operand[11:7];
                    result    = rot64[31:0];
                    carry_out = rot64[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/arm_ex_stage.sv
// Execute stage: ALU / address generation in 1 cycle, iterative MUL/MLA in 32/MAC_BITS_PER_CYCLE+2 cycles.
// While the multiplier runs ex_busy holds upstream and EXMEM receives bubbles.
module arm_ex_stage
    import arm_ex_pkg::*;
#(
    parameter int MAC_BITS_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    arm_ex_if.slave     bus,
    output logic        ex_busy,
    output logic        EXMEM_rd_we,
    output logic        EXMEM_rd_data_sel,
    output logic        EXMEM_ld_byte_or_word,
    output logic [3:0]  EXMEM_mem_write_en,
    output logic [3:0]  EXMEM_rd_num,
    output logic [31:0] EXMEM_alu_result,
    output logic [31:0] EXMEM_store_data,
    output logic        cpsr_we,
    output logic [31:0] cpsr_new
);

    localparam int ITER  = 32 / MAC_BITS_PER_CYCLE;
    localparam int CNT_W = 5;

    logic [31:0] op2, add_a, add_b, alu_res, mem_off, mem_addr, fwd, cpsr_nxt;
    logic [32:0] sum;
    logic        sh_c, add_cin, is_arith, is_mac, launch, ovf;
    logic [3:0]  nzcv;
    alu_op_e     op;
    mac_state_e  state, state_nxt;
    logic [31:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;

    arm_shifter u_shifter (
        .imm_mode (bus.IDEX_is_imm),
        .operand  (bus.IDEX_inst_11_0),
        .rm_data  (bus.IDEX_rm_data),
        .carry_in (bus.IDEX_cpsr[CPSR_FLAG_LSB + FLAG_C]),
        .result   (op2),
        .carry_out(sh_c)
    );

    assign op = alu_op_e'(bus.IDEX_alu_sel);

    always_comb begin
        add_a    = bus.IDEX_rn_data;
        add_b    = op2;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (op)
            OP_SUB, OP_CMP: begin add_b = ~op2; add_cin = 1'b1; end
            OP_RSB: begin add_a = op2; add_b = ~bus.IDEX_rn_data; add_cin = 1'b1; end
            OP_ADD, OP_CMN: ;
            OP_ADC: add_cin = bus.IDEX_cpsr[CPSR_FLAG_LSB + FLAG_C];
            OP_SBC: begin add_b = ~op2; add_cin = bus.IDEX_cpsr[CPSR_FLAG_LSB + FLAG_C]; end
            OP_RSC: begin
                add_a   = op2;
                add_b   = ~bus.IDEX_rn_data;
                add_cin = bus.IDEX_cpsr[CPSR_FLAG_LSB + FLAG_C];
            end
            default: is_arith = 1'b0;
        endcase
        sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
        ovf = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]);
        case (op)
            OP_AND, OP_TST: alu_res = bus.IDEX_rn_data & op2;
            OP_EOR, OP_TEQ: alu_res = bus.IDEX_rn_data ^ op2;
            OP_ORR:         alu_res = bus.IDEX_rn_data | op2;
            OP_MOV:         alu_res = op2;
            OP_BIC:         alu_res = bus.IDEX_rn_data & ~op2;
            OP_MVN:         alu_res = ~op2;
            default:        alu_res = sum[31:0];
        endcase
    end

    assign mem_off  = bus.IDEX_is_imm ? {20'd0, bus.IDEX_inst_11_0} : op2;
    assign mem_addr = bus.IDEX_up_down ? bus.IDEX_rn_data + mem_off : bus.IDEX_rn_data - mem_off;

    assign is_mac = ~bus.IDEX_alu_or_mac;
    assign launch = is_mac & bus.IDEX_rd_we;

    always_comb begin
        state_nxt = state;
        ex_busy   = 1'b0;
        case (state)
            MAC_IDLE: if (launch) begin
                state_nxt = MAC_MUL;
                ex_busy   = 1'b1;
            end
            MAC_MUL: begin
                ex_busy = 1'b1;
                if (cnt == CNT_W'(ITER - 1)) state_nxt = MAC_DONE;
            end
            MAC_DONE: state_nxt = MAC_IDLE;
            default:  state_nxt = MAC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MAC_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            state <= state_nxt;
            if (state == MAC_IDLE && launch) begin
                acc    <= bus.IDEX_mac_sel ? bus.IDEX_rn_data : 32'd0;
                mcand  <= bus.IDEX_rm_data;
                mplier <= bus.IDEX_rs_or_rd_data;
                cnt    <= '0;
            end else if (state == MAC_MUL) begin
                // Radix-2^k step: add the shifted multiplicand times the low multiplier digit
                acc    <= acc + mcand * 32'(mplier[MAC_BITS_PER_CYCLE-1:0]);
                mcand  <= mcand << MAC_BITS_PER_CYCLE;
                mplier <= mplier >> MAC_BITS_PER_CYCLE;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    assign fwd = (state == MAC_DONE) ? acc :
                 bus.IDEX_is_alu_for_mem_addr ? mem_addr : alu_res;

    always_comb begin
        nzcv[FLAG_N] = fwd[31];
        nzcv[FLAG_Z] = (fwd == 32'd0);
        nzcv[FLAG_C] = is_mac ? bus.IDEX_cpsr[CPSR_FLAG_LSB + FLAG_C] : (is_arith ? sum[32] : sh_c);
        nzcv[FLAG_V] = (!is_mac && is_arith) ? ovf : bus.IDEX_cpsr[CPSR_FLAG_LSB + FLAG_V];
        cpsr_nxt     = merge_flags(bus.IDEX_cpsr, nzcv, bus.IDEX_cpsr_mask);
    end

    assign bus.EXID_rd_we               = bus.IDEX_rd_we & ~ex_busy;
    assign bus.EXID_cpsr_we             = bus.IDEX_cpsr_we & ~ex_busy;
    assign bus.EXID_alu_or_mac          = bus.IDEX_alu_or_mac;
    assign bus.EXID_is_alu_for_mem_addr = bus.IDEX_is_alu_for_mem_addr;
    assign bus.EXID_rd_num              = bus.IDEX_rd_sel ? bus.IDEX_inst_15_12 : bus.IDEX_inst_19_16;
    assign bus.EXID_forward_data        = fwd;
    assign bus.EXID_cpsr                = cpsr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            EXMEM_rd_we           <= 1'b0;
            EXMEM_rd_data_sel     <= 1'b0;
            EXMEM_ld_byte_or_word <= 1'b0;
            EXMEM_mem_write_en    <= 4'd0;
            EXMEM_rd_num          <= 4'd0;
            EXMEM_alu_result      <= 32'd0;
            EXMEM_store_data      <= 32'd0;
            cpsr_we               <= 1'b0;
            cpsr_new              <= 32'd0;
        end else begin
            EXMEM_rd_we           <= bus.IDEX_rd_we & ~ex_busy;
            EXMEM_mem_write_en    <= ex_busy ? 4'd0 : bus.IDEX_mem_write_en;
            cpsr_we               <= bus.IDEX_cpsr_we & ~ex_busy;
            EXMEM_rd_data_sel     <= bus.IDEX_rd_data_sel;
            EXMEM_ld_byte_or_word <= bus.IDEX_ld_byte_or_word;
            EXMEM_rd_num          <= bus.EXID_rd_num;
            EXMEM_alu_result      <= fwd;
            EXMEM_store_data      <= bus.IDEX_rs_or_rd_data;
            cpsr_new              <= cpsr_nxt;
        end
    end

endmodule

// File: doc/arm_ex_stage.md
# arm_ex_stage

Execute stage of the forwarding ARM pipeline. It consumes the ID→EX pipeline register (`IDEX_*`) and computes one of three results: the ALU result with barrel-shifted operand 2, the load/store address, or a multi-cycle MUL/MLA product. It publishes the in-flight result back to decode as `EXID_*` for forwarding and hazard detection, and registers the outcome into the EX→MEM register (`EXMEM_*`).

## Interface
Parameters:
- `MAC_BITS_PER_CYCLE`, 2: multiplier bits retired per cycle; supported values are 1, 2 and 4. Iterations = 32/`MAC_BITS_PER_CYCLE`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `IDEX_rn_data`, `IDEX_rm_data`, `IDEX_rs_or_rd_data`, `IDEX_cpsr` in 32 each: forwarded operands and the CPSR snapshot.
- `IDEX_inst_11_0` in 12, `IDEX_inst_19_16` in 4, `IDEX_inst_15_12` in 4: instruction fields.
- `IDEX_alu_sel` in 4, `IDEX_cpsr_mask` in 4: ARM opcode, and the NZCV update mask (bit3 = N).
- `IDEX_rd_we`, `IDEX_cpsr_we`, `IDEX_rd_sel`, `IDEX_rd_data_sel`, `IDEX_is_imm`, `IDEX_alu_or_mac`, `IDEX_up_down`, `IDEX_mac_sel`, `IDEX_is_alu_for_mem_addr`, `IDEX_ld_byte_or_word` in 1 each.
- `IDEX_mem_write_en` in 4: byte-lane store enables.
- `EXID_rd_we`, `EXID_cpsr_we`, `EXID_alu_or_mac`, `EXID_is_alu_for_mem_addr` out 1 each: combinational status of the current EX instruction.
- `EXID_rd_num` out 4; `EXID_forward_data`, `EXID_cpsr` out 32 each: combinational result, destination and flags.
- `ex_busy` out 1: the multiplier is occupied; IF, ID and IDEX must hold.
- `EXMEM_rd_we`, `EXMEM_rd_data_sel`, `EXMEM_ld_byte_or_word` out 1 each; `EXMEM_mem_write_en` out 4; `EXMEM_rd_num` out 4; `EXMEM_alu_result`, `EXMEM_store_data` out 32 each: registered stage outputs.
- `cpsr_we` out 1, `cpsr_new` out 32: registered CPSR write to the register file.

## Operation
- **Operand 2, immediate form** (`is_imm`=1, data-processing): `ror(zext(imm[7:0]), 2*imm[11:8])`. Shifter carry = bit 31 of the result when the rotate is nonzero; otherwise the carry equals CPSR.C.
- **Operand 2, register form:** `rm_data` shifted by type `inst[6:5]` (LSL, LSR, ASR, ROR) by amount `inst[11:7]`.
  - LSR #0 and ASR #0 mean a shift by 32.
  - ROR #0 means RRX (rotate right through CPSR.C).
  - Register-specified shift amounts are not supported; `inst[4]` is ignored.
- **ALU:** all 16 ARM opcodes. ADC, SBC and RSC use `IDEX_cpsr.C`.
  - TST, TEQ, CMP and CMN produce flags only; decode guarantees `rd_we`=0 for them.
- **Flags:**
  - N = result[31]; Z = (result==0).
  - C = adder carry (for SUB-type ops, NOT borrow) or the shifter carry for logical ops.
  - V = signed overflow for arithmetic ops; unchanged for logical ops.
  - `cpsr_new` = `IDEX_cpsr` with only the bits selected by `cpsr_mask` replaced.
- **Memory address** (`is_alu_for_mem_addr`=1): `rn_data ± offset`, where `up_down`=1 adds and 0 subtracts.
  - Offset = `zext(inst_11_0)` when `is_imm`=1; otherwise the shifted `rm_data`.
  - `EXMEM_store_data` = `rs_or_rd_data`.
- **Destination:** `rd_num` = `inst_15_12` when `rd_sel`=1, else `inst_19_16`.
- **MAC:** product = `rm_data * rs_or_rd_data`, low 32 bits. MLA (`mac_sel`=1) adds `rn_data`.
  - Only N and Z may update; C and V keep their `IDEX_cpsr` values.
- **Bubbles:** an instruction with `rd_we`=`cpsr_we`=0 and `mem_write_en`=0 passes through without side effects.

## Timing
- **Reset:** the FSM goes to IDLE and `ex_busy`=0. All `EXMEM_*` enables and `cpsr_we` are 0; all data registers are 0. Reset asserted mid-multiply aborts it with no write.
- **ALU and address ops:** 1 cycle; `EXMEM_*` is valid the cycle after the op is present on `IDEX_*`. `EXID_*` reflects `IDEX_*` combinationally in the same cycle.
- **MAC FSM states:** IDLE → MUL → DONE → IDLE.
  - IDLE → MUL when `alu_or_mac`=0 and `rd_we`=1. On that edge it loads the accumulator (`rn_data` or 0), the multiplicand and the multiplier, and clears the counter.
  - MUL retires `MAC_BITS_PER_CYCLE` bits per cycle. It moves to DONE when the counter reaches 32/`MAC_BITS_PER_CYCLE`−1.
  - DONE presents the product on `EXID_*` and registers it into `EXMEM` and `cpsr_*`, then returns to IDLE.
- **`ex_busy`:** high in the IDLE launch cycle and in every MUL cycle, and low in DONE. With the default parameter, `ex_busy` is high for 17 cycles and the product lands in `EXMEM` 18 cycles after launch.
- **While `ex_busy`=1:**
  - `EXMEM` receives a bubble (all enables 0) and `cpsr_we`=0.
  - `EXID_rd_we` and `EXID_cpsr_we` are 0.
  - `IDEX_*` must stay stable; upstream gates its writes with `ex_busy`.
- **Back-to-back MACs:** the second MAC launches in the cycle after DONE.

## Structure
- **Package `arm_ex_pkg`:**
  - ALU opcode enum, matching the ARM `alu_sel` encodings (AND=0 … MVN=15).
  - Shift type enum.
  - MAC state enum.
  - NZCV bit-index constants.
- **Sub-module `arm_shifter`:** combinational immediate-rotate and shift-by-immediate logic with carry-out, including the RRX and #0 special cases.

## Test plan
- ADD with `rn`=0x7FFFFFFF, imm 1, `cpsr_mask`=4'hF → `EXMEM_alu_result`=0x80000000, NZCV=1001 next cycle.
- SUB with `rm` LSR #0, `rm`=0x80000000, `rn`=0 → operand 2 = 0, result 0, Z=1, C=1.
- LDR address with `rn`=0x1000, imm12=0x010, `up_down`=0 → `EXMEM_alu_result`=0x0FF0, `EXMEM_rd_data_sel` passed through.
- MLA with `rm`=3, `rs`=0xFFFFFFFF, `rn`=5 → `ex_busy` high for 17 cycles, `EXID_rd_we` low until DONE, then `EXMEM_alu_result`=2 with C and V unchanged.
- Assert `rst` in the 8th MUL cycle → `ex_busy`=0 and `EXMEM_rd_we`=0 next cycle; no product is ever written.
- CMP followed by ADC on a dependent flag → `EXID_cpsr` shows the new C combinationally in the CMP cycle.
